// File: rtl/at_hazard_ctrl.sv
// at_hazard_ctrl: Tuse/Tnew hazard controller for the in-order pipeline.
// Tracks destination registers and their remaining Tnew across NSTAGE
// post-decode stages, raises a decode stall when a source is needed before
// its producer is ready, selects forwarded operands, and interlocks
// HI/LO users and new mult/div starts against a busy mult/div unit.
//
// Interface contract: decode presents an instruction with dec_valid; the
// instruction is accepted on a clock edge when dec_valid=1 and stall=0.
// While stall=1 the decode inputs must stay unchanged and a bubble
// (dst_a=0, tnew=0) enters stage 1.
module at_hazard_ctrl #(
  parameter int NSTAGE   = 3,
  parameter int NSRC     = 2,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int SW       = $clog2(NSTAGE+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [NSRC*AW-1:0]   dec_src_a,
  input  logic [NSRC*TW-1:0]   dec_src_tuse,
  input  logic [AW-1:0]        dec_dst_a,
  input  logic [TW-1:0]        dec_dst_tnew,
  input  logic                 dec_md_start,
  input  logic                 dec_md_is_div,
  input  logic                 dec_md_use,
  input  logic [NSRC*DW-1:0]   rf_val,
  input  logic [NSTAGE*DW-1:0] stage_val,
  output logic                 stall,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic [NSRC*DW-1:0]   fwd_val,
  output logic [NSRC-1:0]      fwd_pending,
  output logic                 md_busy
);

  localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW     = $clog2(MD_MAX + 1);

  // Tracking state, index 1 = EX ... NSTAGE = WB.
  logic [AW-1:0] dst_a_q [1:NSTAGE];
  logic [TW-1:0] tnew_q  [1:NSTAGE];

  // Remaining mult/div busy cycles.
  logic [CW-1:0] md_cnt_q;
  logic [CW-1:0] md_cnt_d;

  // Per-source match results.
  logic [NSRC-1:0] found;
  logic [SW-1:0]   hit_k    [NSRC];
  logic [TW-1:0]   hit_tnew [NSRC];
  logic [NSRC-1:0] src_stall;
  logic            stall_md;
  logic            md_accept;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
    return (x != '0) ? (x - TW'(1)) : '0;
  endfunction

  // Find the youngest in-flight producer of each source and its stall need.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      found[i]     = 1'b0;
      hit_k[i]     = '0;
      hit_tnew[i]  = '0;
      if (dec_valid && (dec_src_a[i*AW +: AW] != '0)) begin
        // Walk oldest to youngest so the youngest match is the one kept.
        for (int k = NSTAGE; k >= 1; k--) begin
          if (dst_a_q[k] == dec_src_a[i*AW +: AW]) begin
            found[i]    = 1'b1;
            hit_k[i]    = SW'(k);
            hit_tnew[i] = tnew_q[k];
          end
        end
      end
      src_stall[i] = found[i] && (dec_src_tuse[i*TW +: TW] < hit_tnew[i]);
    end
  end

  assign md_busy   = (md_cnt_q != '0);
  assign stall_md  = dec_valid && (dec_md_use || dec_md_start) && md_busy;
  assign stall     = (|src_stall) || stall_md;
  assign md_accept = dec_valid && !stall && dec_md_start;

  // Forward selection: ready producers forward, unready ones flag pending.
  always_comb begin
    fwd_sel     = '0;
    fwd_pending = '0;
    fwd_val     = rf_val;
    for (int i = 0; i < NSRC; i++) begin
      if (found[i]) begin
        if (hit_tnew[i] == '0) begin
          fwd_sel[i*SW +: SW] = hit_k[i];
          for (int k = 1; k <= NSTAGE; k++) begin
            if (hit_k[i] == SW'(k)) begin
              fwd_val[i*DW +: DW] = stage_val[(k-1)*DW +: DW];
            end
          end
        end else if (!stall) begin
          fwd_pending[i] = 1'b1;
        end
      end
    end
  end

  // Next mult/div count: load on an accepted start, else count down to 0.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_accept) begin
      md_cnt_d = dec_md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  // Advance the tracking pipeline; a stalled or empty decode injects a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        dst_a_q[k] <= '0;
        tnew_q[k]  <= '0;
      end
    end else begin
      if (stall || !dec_valid) begin
        dst_a_q[1] <= '0;
        tnew_q[1]  <= '0;
      end else begin
        dst_a_q[1] <= dec_dst_a;
        tnew_q[1]  <= sat_dec(dec_dst_tnew);
      end
      for (int k = 2; k <= NSTAGE; k++) begin
        dst_a_q[k] <= dst_a_q[k-1];
        tnew_q[k]  <= sat_dec(tnew_q[k-1]);
      end
    end
  end

  // Mult/div busy counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule
